zap_wb_arbiter: RTL
===================

// Module: zap_wb_arbiter
// PURPOSE
// - Shares the one external Wishbone bus between two cache masters: M0 = data cache top, M1 = instruction cache top.
// - Each master presents next-cycle (_nxt) Wishbone signals. The arbiter selects one master and registers its signals onto the bus.
// - Routes ack and error back to the owner. Holds ownership across bursts. Aborts a stalled access after a programmable timeout.
// PARAMETERS
// - TIMEOUT_CYCLES  default 1023  stalled-strobe cycles before abort. 0 = watchdog disabled. Max 65535.
// PORTS
// - i_clk              in   1   clock
// - i_reset            in   1   reset, asynchronous, active-high
// - i_mX_wb_cyc_nxt    in   1   X in {0,1}: master X cycle request (next cycle)
// - i_mX_wb_stb_nxt    in   1   master X strobe
// - i_mX_wb_wen_nxt    in   1   master X write enable
// - i_mX_wb_sel_nxt    in   4   master X byte selects
// - i_mX_wb_dat_nxt    in   32  master X write data
// - i_mX_wb_adr_nxt    in   32  master X byte address
// - i_mX_wb_cti_nxt    in   3   master X cycle type identifier
// - o_mX_wb_ack        out  1   ack routed to master X
// - o_mX_wb_err        out  1   timeout abort to master X
// - o_wb_cyc/stb/wen   out  1   registered bus controls
// - o_wb_sel           out  4   registered bus byte selects
// - o_wb_dat/o_wb_adr  out  32  registered bus write data / address
// - o_wb_cti           out  3   registered bus cycle type
// - i_wb_ack           in   1   bus ack. Read data i_wb_dat goes to both masters directly, not through this block.
// - o_gnt              out  2   current owner: 00 = IDLE, 01 = M0, 10 = M1
// - o_timeout          out  1   one-cycle pulse when the watchdog fires
// BEHAVIOUR
// - Reset values: state IDLE; all o_wb_* 0 (o_wb_cti = 3'b000, CTI_CLASSIC); o_mX_* 0; o_gnt 0; o_timeout 0; counter 0.
// - FSM states: IDLE, M0, M1, held in state_ff. The next state is computed combinationally and registered together with the bus outputs.
// - Boundary: (!o_wb_stb) || (o_wb_stb && i_wb_ack). Ownership may change only at a boundary.
// - At a boundary:
//   - If the owner's cyc_nxt is 1, the owner keeps the bus. This covers bursts and multi-beat accesses.
//   - Otherwise the new owner is chosen among requesters (cyc_nxt = 1). With no requester, next state is IDLE.
// - Output mux: o_wb_*_nxt = signals of the state_nxt owner; all zeros when IDLE. These are registered on the next edge.
//   - Latency is one cycle, identical to a master driving the bus directly.
// - Ack routing: o_mX_wb_ack = i_wb_ack && state_ff == MX. i_wb_ack while IDLE is ignored.
// - Watchdog (TIMEOUT_CYCLES != 0):
//   - 16-bit counter increments each cycle with o_wb_stb && !i_wb_ack. It clears on ack, on stb = 0, and on any state change.
//   - When the counter reaches TIMEOUT_CYCLES - 1 with no ack, in the next cycle:
//     - o_wb_cyc = o_wb_stb = 0;
//     - o_mX_wb_ack = o_mX_wb_err = 1 to the owner for exactly one cycle;
//     - o_timeout = 1; state goes to IDLE; counter clears.
//   - After that, normal arbitration resumes. A master that still requests is regranted.
// - Simultaneous ack and timeout expiry: the ack wins and no abort occurs.
// - Async reset mid-transaction: all outputs go to reset values immediately, with no clock edge. Masters must restart.
// CONFIGURATION
// - ZAP_WB_ARB_RR_EN defined:
//   - Round-robin. A 1-bit last_gnt register (reset 0 = M0) records the master granted most recently.
//   - When both request at a boundary, the master != last_gnt is granted. last_gnt updates on every grant into M0/M1.
// - ZAP_WB_ARB_RR_EN undefined: fixed priority; M0 (data cache) always beats M1. No last_gnt register.
// TESTING
// - Collision, fixed priority:
//   - Stimulus: from IDLE, m0 and m1 cyc/stb_nxt rise together; m0 adr = 0x100, m1 adr = 0x200.
//   - Response: next cycle o_wb_adr = 0x100 and o_gnt = 01. After m0's ack and m0 cyc_nxt = 0, o_wb_adr = 0x200 and o_gnt = 10.
// - Burst hold:
//   - Stimulus: m1 issues a 4-beat burst (cti 010, 010, 010, 111); m0 requests at beat 2.
//   - Response: o_gnt stays 10 until the beat-4 ack, then becomes 01.
// - Ack routing:
//   - Stimulus: i_wb_ack = 1 while o_gnt = 10.
//   - Response: o_m1_wb_ack = 1, o_m0_wb_ack = 0. i_wb_ack while IDLE gives both acks 0.
// - Watchdog:
//   - Stimulus: TIMEOUT_CYCLES = 8; m0 read, i_wb_ack held 0.
//   - Response: on the 9th cycle o_wb_stb = o_wb_cyc = 0, o_m0_wb_err = o_m0_wb_ack = 1 for 1 cycle, o_timeout = 1.
//   - Stimulus: ack in the 8th cycle.
//   - Response: no abort.
// - Round-robin (ZAP_WB_ARB_RR_EN):
//   - Stimulus: both masters issue back-to-back single-beat accesses.
//   - Response: grants alternate 01, 10, 01, 10. Without the macro, o_gnt stays 01 while m0 requests.
// - Async reset:
//   - Stimulus: assert i_reset between clock edges mid-burst.
//   - Response: o_wb_cyc = o_wb_stb = 0 and o_gnt = 00 before the next edge. After release, the bus stays idle until a new request.

Source files
------------

// File: rtl/zap_wb_arbiter.sv
// -----------------------------------------------------------------------------
// zap_wb_arbiter
//
// Shares one external Wishbone bus between two cache masters:
//   M0 = data cache, M1 = instruction cache.
// Each master presents next-cycle (_nxt) Wishbone signals. The arbiter picks an
// owner and registers that owner's signals onto the bus, so bus latency is the
// same as a master driving the bus directly. Ownership changes only at a
// transfer boundary, which means bursts stay with one owner. A watchdog aborts
// a strobe that has stalled for too long.
//
// Build option:
//   ZAP_WB_ARB_RR_EN  defined   -> round-robin tie break (last_gnt register)
//                     undefined -> fixed priority, M0 beats M1
//
// Parameter:
//   TIMEOUT_CYCLES   stalled-strobe cycles before abort (0 disables, max 65535)
//
// Ports:
//   i_clk, i_reset          clock, asynchronous active-high reset
//   i_mX_wb_*_nxt           master X next-cycle cyc/stb/wen/sel/dat/adr/cti
//   o_mX_wb_ack/err         ack / timeout-abort routed to master X
//   o_wb_*                  registered bus cyc/stb/wen/sel/dat/adr/cti
//   i_wb_ack                bus acknowledge
//   o_gnt                   current owner: 00 idle, 01 M0, 10 M1
//   o_timeout               one-cycle pulse when the watchdog fires
// -----------------------------------------------------------------------------
module zap_wb_arbiter #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic        i_clk,
  input  logic        i_reset,

  input  logic        i_m0_wb_cyc_nxt,
  input  logic        i_m0_wb_stb_nxt,
  input  logic        i_m0_wb_wen_nxt,
  input  logic [3:0]  i_m0_wb_sel_nxt,
  input  logic [31:0] i_m0_wb_dat_nxt,
  input  logic [31:0] i_m0_wb_adr_nxt,
  input  logic [2:0]  i_m0_wb_cti_nxt,
  output logic        o_m0_wb_ack,
  output logic        o_m0_wb_err,

  input  logic        i_m1_wb_cyc_nxt,
  input  logic        i_m1_wb_stb_nxt,
  input  logic        i_m1_wb_wen_nxt,
  input  logic [3:0]  i_m1_wb_sel_nxt,
  input  logic [31:0] i_m1_wb_dat_nxt,
  input  logic [31:0] i_m1_wb_adr_nxt,
  input  logic [2:0]  i_m1_wb_cti_nxt,
  output logic        o_m1_wb_ack,
  output logic        o_m1_wb_err,

  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_wen,
  output logic [3:0]  o_wb_sel,
  output logic [31:0] o_wb_dat,
  output logic [31:0] o_wb_adr,
  output logic [2:0]  o_wb_cti,
  input  logic        i_wb_ack,

  output logic [1:0]  o_gnt,
  output logic        o_timeout
);

  // One-hot owner encoding: bit X set means master X owns the bus.
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] M0   = 2'b01;
  localparam logic [1:0] M1   = 2'b10;

  logic [1:0] state_ff;
  logic [1:0] state_nxt;
  logic [1:0] tie_winner;
  logic [1:0] err_ff;
  logic       timeout_fire;
  logic       boundary;

  // Ownership may move only when no strobe is pending or it is being acked.
  assign boundary = !o_wb_stb || i_wb_ack;

`ifdef ZAP_WB_ARB_RR_EN
  // 0 = M0 granted most recently, 1 = M1.
  logic last_gnt_ff;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)
      last_gnt_ff <= 1'b0;
    else if (state_nxt != IDLE)
      last_gnt_ff <= state_nxt[1];
  end

  assign tie_winner = last_gnt_ff ? M0 : M1;
`else
  assign tie_winner = M0;
`endif

  always_comb begin
    state_nxt = state_ff;
    if (timeout_fire) begin
      state_nxt = IDLE;
    end else if (boundary) begin
      if (state_ff == M0 && i_m0_wb_cyc_nxt)
        state_nxt = M0;
      else if (state_ff == M1 && i_m1_wb_cyc_nxt)
        state_nxt = M1;
      else if (i_m0_wb_cyc_nxt && i_m1_wb_cyc_nxt)
        state_nxt = tie_winner;
      else if (i_m0_wb_cyc_nxt)
        state_nxt = M0;
      else if (i_m1_wb_cyc_nxt)
        state_nxt = M1;
      else
        state_nxt = IDLE;
    end
  end

  // Watchdog: counts stalled strobe cycles of the current owner.
  generate
    if (TIMEOUT_CYCLES != 0) begin : g_wdog
      localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
      logic [15:0] cnt_ff;

      // An ack in the expiry cycle wins, so no abort then.
      assign timeout_fire = o_wb_stb && !i_wb_ack && (cnt_ff == TO_LAST);

      always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
          cnt_ff <= 16'd0;
        else if (timeout_fire || (state_nxt != state_ff) || !o_wb_stb || i_wb_ack)
          cnt_ff <= 16'd0;
        else
          cnt_ff <= cnt_ff + 16'd1;
      end
    end else begin : g_no_wdog
      assign timeout_fire = 1'b0;
    end
  endgenerate

  // Bus outputs follow the owner chosen for the next cycle.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_ff  <= IDLE;
      o_wb_cyc  <= 1'b0;
      o_wb_stb  <= 1'b0;
      o_wb_wen  <= 1'b0;
      o_wb_sel  <= 4'd0;
      o_wb_dat  <= 32'd0;
      o_wb_adr  <= 32'd0;
      o_wb_cti  <= 3'b000;
      err_ff    <= 2'b00;
      o_timeout <= 1'b0;
    end else begin
      state_ff  <= state_nxt;
      // state_ff is one-hot, so it names the aborted owner directly.
      err_ff    <= timeout_fire ? state_ff : 2'b00;
      o_timeout <= timeout_fire;
      case (state_nxt)
        M0: begin
          o_wb_cyc <= i_m0_wb_cyc_nxt;
          o_wb_stb <= i_m0_wb_stb_nxt;
          o_wb_wen <= i_m0_wb_wen_nxt;
          o_wb_sel <= i_m0_wb_sel_nxt;
          o_wb_dat <= i_m0_wb_dat_nxt;
          o_wb_adr <= i_m0_wb_adr_nxt;
          o_wb_cti <= i_m0_wb_cti_nxt;
        end
        M1: begin
          o_wb_cyc <= i_m1_wb_cyc_nxt;
          o_wb_stb <= i_m1_wb_stb_nxt;
          o_wb_wen <= i_m1_wb_wen_nxt;
          o_wb_sel <= i_m1_wb_sel_nxt;
          o_wb_dat <= i_m1_wb_dat_nxt;
          o_wb_adr <= i_m1_wb_adr_nxt;
          o_wb_cti <= i_m1_wb_cti_nxt;
        end
        default: begin
          o_wb_cyc <= 1'b0;
          o_wb_stb <= 1'b0;
          o_wb_wen <= 1'b0;
          o_wb_sel <= 4'd0;
          o_wb_dat <= 32'd0;
          o_wb_adr <= 32'd0;
          o_wb_cti <= 3'b000;
        end
      endcase
    end
  end

  // Ack goes to the current owner; an abort also acks the aborted owner.
  logic [1:0] ack_vec;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_route
      assign ack_vec[gi] = (i_wb_ack && state_ff[gi]) || err_ff[gi];
    end
  endgenerate

  assign o_m0_wb_ack = ack_vec[0];
  assign o_m1_wb_ack = ack_vec[1];
  assign o_m0_wb_err = err_ff[0];
  assign o_m1_wb_err = err_ff[1];
  assign o_gnt       = state_ff;

endmodule
